// File: rtl/gpr_wb_arbiter_if.sv
// Bus bundle between the writeback arbiter, its two producers and the GPR write port.
// The slave modport is the arbiter's view; the master modport is the producer/GPR side.
interface gpr_wb_arbiter_if #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pipe_we;
    logic [AW-1:0] pipe_rd;
    logic [DW-1:0] pipe_data;
    logic          aux_valid;
    logic          aux_ready;
    logic [AW-1:0] aux_rd;
    logic [DW-1:0] aux_data;
    logic          stall_req;
    logic [CW-1:0] fifo_count;
    logic          regWrite;
    logic [AW-1:0] write_register;
    logic [DW-1:0] w_data;

    modport slave (
        input  pipe_we, pipe_rd, pipe_data, aux_valid, aux_rd, aux_data,
        output aux_ready, stall_req, fifo_count, regWrite, write_register, w_data
    );

    modport master (
        output pipe_we, pipe_rd, pipe_data, aux_valid, aux_rd, aux_data,
        input  aux_ready, stall_req, fifo_count, regWrite, write_register, w_data
    );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter: pipeline writes win, aux results queue in a small FIFO and drain when idle.
// Define GPR_WB_PENDING_EN to add the pending_mask output (per-register FIFO occupancy).
module gpr_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8,
    parameter int AW         = 5,
    parameter int DW         = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    gpr_wb_arbiter_if.slave       bus
`ifdef GPR_WB_PENDING_EN
    ,
    output logic [2**AW-1:0]      pending_mask
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [AW-1:0] mem_rd_q   [DEPTH];
    logic [DW-1:0] mem_data_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          reg_we_q, reg_we_d;
    logic [AW-1:0] reg_rd_q, reg_rd_d;
    logic [DW-1:0] reg_data_q, reg_data_d;

    logic          pipe_eff, fifo_empty, aux_ready, push, pop;
    logic [AW-1:0] head_rd;
    logic [DW-1:0] head_data;

    always_comb begin
        pipe_eff   = bus.pipe_we && (bus.pipe_rd != '0);
        fifo_empty = (count_q == '0);
        // Readiness comes only from the registered count, so a same-cycle drain gives no credit.
        aux_ready  = (count_q < CW'(DEPTH));
        push       = bus.aux_valid && aux_ready && (bus.aux_rd != '0);
        pop        = !pipe_eff && !fifo_empty;
        head_rd    = mem_rd_q[rd_ptr_q];
        head_data  = mem_data_q[rd_ptr_q];

        reg_we_d   = 1'b0;
        reg_rd_d   = '0;
        reg_data_d = '0;
        if (pipe_eff) begin
            reg_we_d   = 1'b1;
            reg_rd_d   = bus.pipe_rd;
            reg_data_d = bus.pipe_data;
        end else if (pop) begin
            reg_we_d   = 1'b1;
            reg_rd_d   = head_rd;
            reg_data_d = head_data;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        starve_d = starve_q;
        if (fifo_empty || pop)
            starve_d = '0;
        else if (starve_q < SW'(STARVE_MAX))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            reg_we_q   <= 1'b0;
            reg_rd_q   <= '0;
            reg_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            reg_we_q   <= reg_we_d;
            reg_rd_q   <= reg_rd_d;
            reg_data_q <= reg_data_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_rd_q[wr_ptr_q]   <= bus.aux_rd;
            mem_data_q[wr_ptr_q] <= bus.aux_data;
        end
    end

    assign bus.aux_ready      = aux_ready;
    assign bus.stall_req      = (starve_q == SW'(STARVE_MAX));
    assign bus.fifo_count     = count_q;
    assign bus.regWrite       = reg_we_q;
    assign bus.write_register = reg_rd_q;
    assign bus.w_data         = reg_data_q;

`ifdef GPR_WB_PENDING_EN
    // One occupancy counter per register so repeated targets stay pending until the last drains.
    assign pending_mask[0] = 1'b0;
    for (genvar gi = 1; gi < 2**AW; gi++) begin : g_pend
        logic [CW-1:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q + CW'(push && (bus.aux_rd == AW'(gi)))
                          - CW'(pop && (head_rd == AW'(gi)));
        end
        always_ff @(posedge clk) begin
            if (!reset) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end
        assign pending_mask[gi] = (cnt_q != '0);
    end
`endif
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed vector table, hand-written corner
// sequences (starvation stall, reset mid-drain) and random traffic against a queue model.
module tb_gpr_wb_arbiter;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
    localparam int AW         = 5;
    localparam int DW         = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    gpr_wb_arbiter_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();
`ifdef GPR_WB_PENDING_EN
    logic [2**AW-1:0] pending_mask;
`endif

    gpr_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef GPR_WB_PENDING_EN
        ,
        .pending_mask (pending_mask)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: a queue of pending writes ----------------
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          m_q[$];
    int            m_starve = 0;
    bit            m_we = 0;
    logic [AW-1:0] m_rd = '0;
    logic [DW-1:0] m_data = '0;

    task automatic model_step(input bit rn, input bit pwe, input logic [AW-1:0] prd,
                              input logic [DW-1:0] pd, input bit av,
                              input logic [AW-1:0] ard, input logic [DW-1:0] ad);
        int  sz;
        bit  eff, acc;
        ent_t e;
        if (!rn) begin
            m_q.delete();
            m_starve = 0;
            m_we = 0; m_rd = '0; m_data = '0;
        end else begin
            sz  = m_q.size();
            eff = pwe && (prd != 0);
            acc = av && (sz < DEPTH);
            if (eff) begin
                m_we = 1; m_rd = prd; m_data = pd;
            end else if (sz > 0) begin
                e = m_q.pop_front();
                m_we = 1; m_rd = e.rd; m_data = e.data;
            end else begin
                m_we = 0; m_rd = '0; m_data = '0;
            end
            if (sz == 0 || !eff) m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve++;
            if (acc && ard != 0) m_q.push_back('{rd: ard, data: ad});
        end
    endtask

    task automatic step(input bit rn, input bit pwe, input logic [AW-1:0] prd,
                        input logic [DW-1:0] pd, input bit av,
                        input logic [AW-1:0] ard, input logic [DW-1:0] ad);
        reset         = rn;
        bus.pipe_we   = pwe;
        bus.pipe_rd   = prd;
        bus.pipe_data = pd;
        bus.aux_valid = av;
        bus.aux_rd    = ard;
        bus.aux_data  = ad;
        model_step(rn, pwe, prd, pd, av, ard, ad);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".regWrite"}, 64'(bus.regWrite), 64'(m_we));
        if (m_we) begin
            check({tag, ".write_register"}, 64'(bus.write_register), 64'(m_rd));
            check({tag, ".w_data"}, 64'(bus.w_data), 64'(m_data));
        end
        check({tag, ".fifo_count"}, 64'(bus.fifo_count), 64'(m_q.size()));
        check({tag, ".aux_ready"}, 64'(bus.aux_ready), 64'(m_q.size() < DEPTH));
        check({tag, ".stall_req"}, 64'(bus.stall_req), 64'(m_starve == STARVE_MAX));
`ifdef GPR_WB_PENDING_EN
        begin
            logic [2**AW-1:0] exp_mask;
            exp_mask = '0;
            foreach (m_q[k]) exp_mask[m_q[k].rd] = 1'b1;
            check({tag, ".pending_mask"}, 64'(pending_mask), 64'(exp_mask));
        end
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            rn;
        bit            pwe;
        logic [AW-1:0] prd;
        logic [DW-1:0] pd;
        bit            av;
        logic [AW-1:0] ard;
        logic [DW-1:0] ad;
        bit            e_we;
        logic [AW-1:0] e_rd;
        logic [DW-1:0] e_data;
        int            e_cnt;
        bit            e_rdy;
        bit            e_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rn, bit pwe, logic [AW-1:0] prd, logic [DW-1:0] pd,
                                bit av, logic [AW-1:0] ard, logic [DW-1:0] ad,
                                bit e_we, logic [AW-1:0] e_rd, logic [DW-1:0] e_data,
                                int e_cnt, bit e_rdy, bit e_stall);
        vec_t v;
        v.rn = rn; v.pwe = pwe; v.prd = prd; v.pd = pd;
        v.av = av; v.ard = ard; v.ad = ad;
        v.e_we = e_we; v.e_rd = e_rd; v.e_data = e_data;
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_stall = e_stall;
        return v;
    endfunction

    initial begin
        bus.pipe_we = 0; bus.pipe_rd = '0; bus.pipe_data = '0;
        bus.aux_valid = 0; bus.aux_rd = '0; bus.aux_data = '0;

        //             rn pwe prd pdata          av ard adata         we rd  data          cnt rdy stall
        vecs.push_back(mk(0, 0, 0, 0,             0, 0, 0,            0, 0,  0,            0, 1, 0));
        vecs.push_back(mk(1, 1, 5, 32'hDEADBEEF,  0, 0, 0,            1, 5,  32'hDEADBEEF, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,             1, 7, 32'h12345678, 0, 0,  0,            1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,             0, 0, 0,            1, 7,  32'h12345678, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0000AAAA,  1, 0, 32'h0000BBBB, 0, 0,  0,            0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,             0, 0, 0,            0, 0,  0,            0, 1, 0));
        vecs.push_back(mk(1, 1, 9, 32'h11111111,  1, 12, 32'h22222222,1, 9,  32'h11111111, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,             0, 0, 0,            1, 12, 32'h22222222, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 32'h5,         1, 13, 32'h33333333,0, 0,  0,            1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 32'h6,         0, 0, 0,            1, 13, 32'h33333333, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0,             0, 0, 0,            0, 0,  0,            0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(vecs[i].rn, vecs[i].pwe, vecs[i].prd, vecs[i].pd,
                 vecs[i].av, vecs[i].ard, vecs[i].ad);
            $display("%s: rst_n=%0d pipe_we=%0d rd=%0d aux_valid=%0d aux_rd=%0d -> regWrite=%0d wr=%0d data=%h count=%0d",
                     t, vecs[i].rn, vecs[i].pwe, vecs[i].prd, vecs[i].av, vecs[i].ard,
                     bus.regWrite, bus.write_register, bus.w_data, bus.fifo_count);
            check({t, ".regWrite"}, 64'(bus.regWrite), 64'(vecs[i].e_we));
            if (vecs[i].e_we || !vecs[i].rn) begin
                check({t, ".write_register"}, 64'(bus.write_register), 64'(vecs[i].e_rd));
                check({t, ".w_data"}, 64'(bus.w_data), 64'(vecs[i].e_data));
            end
            check({t, ".fifo_count"}, 64'(bus.fifo_count), 64'(vecs[i].e_cnt));
            check({t, ".aux_ready"}, 64'(bus.aux_ready), 64'(vecs[i].e_rdy));
            check({t, ".stall_req"}, 64'(bus.stall_req), 64'(vecs[i].e_stall));
        end

        // ---------------- starvation: pipe hogs the port while 4 aux entries wait ----------------
        step(0, 0, '0, '0, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("starve.ready_before_push%0d", i), 64'(bus.aux_ready), 64'(1));
            step(1, 1, 5'd3, 32'(i), 1, 5'(8 + i), 32'hA0 + 32'(i));
            check($sformatf("starve.count%0d", i), 64'(bus.fifo_count), 64'(i + 1));
        end
        check("starve.full_ready", 64'(bus.aux_ready), 64'(0));
        check("starve.stall_early", 64'(bus.stall_req), 64'(0));
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 5'd3, 32'h100 + 32'(k), 0, '0, '0);
            check($sformatf("starve.no_stall%0d", k), 64'(bus.stall_req), 64'(0));
        end
        step(1, 1, 5'd3, 32'h200, 0, '0, '0);
        check("starve.stall_set", 64'(bus.stall_req), 64'(1));
        step(1, 1, 5'd3, 32'h201, 0, '0, '0);
        check("starve.pipe_wins_we", 64'(bus.regWrite), 64'(1));
        check("starve.pipe_wins_rd", 64'(bus.write_register), 64'(3));
        check("starve.stall_held", 64'(bus.stall_req), 64'(1));
        check("starve.count_held", 64'(bus.fifo_count), 64'(4));
        $display("starve: stall_req observed after head blocked %0d cycles", STARVE_MAX);
        for (int i = 0; i < 4; i++) begin
            idle();
            $display("drain%0d: regWrite=%0d wr=%0d data=%h", i, bus.regWrite, bus.write_register, bus.w_data);
            check($sformatf("drain%0d.we", i), 64'(bus.regWrite), 64'(1));
            check($sformatf("drain%0d.rd", i), 64'(bus.write_register), 64'(8 + i));
            check($sformatf("drain%0d.data", i), 64'(bus.w_data), 64'(32'hA0 + 32'(i)));
            check($sformatf("drain%0d.stall", i), 64'(bus.stall_req), 64'(0));
            check($sformatf("drain%0d.count", i), 64'(bus.fifo_count), 64'(3 - i));
        end

        // ---------------- reset while draining: buffered entries are lost ----------------
        step(0, 0, '0, '0, 0, '0, '0);
        for (int i = 0; i < 3; i++) step(1, 1, 5'd3, '0, 1, 5'(20 + i), 32'hC0 + 32'(i));
        idle();
        check("rstdrain.first_rd", 64'(bus.write_register), 64'(20));
        check("rstdrain.count_before", 64'(bus.fifo_count), 64'(2));
        step(0, 0, '0, '0, 0, '0, '0);
        $display("rstdrain: reset applied with entries buffered, count=%0d regWrite=%0d", bus.fifo_count, bus.regWrite);
        check("rstdrain.count", 64'(bus.fifo_count), 64'(0));
        check("rstdrain.we", 64'(bus.regWrite), 64'(0));
        check("rstdrain.ready", 64'(bus.aux_ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
            idle();
            check($sformatf("rstdrain.quiet%0d", i), 64'(bus.regWrite), 64'(0));
        end

        // ---------------- random traffic against the queue model ----------------
        step(0, 0, '0, '0, 0, '0, '0);
        check_model("rnd.reset");
        for (int c = 0; c < 3000; c++) begin
            bit            rn, pwe, av;
            logic [AW-1:0] prd, ard;
            rn  = ($urandom_range(0, 199) != 0);
            pwe = ($urandom_range(0, 9) < 6);
            if (m_starve == STARVE_MAX && $urandom_range(0, 3) != 0) pwe = 0;
            prd = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            av  = ($urandom_range(0, 1) == 1);
            ard = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            step(rn, pwe, prd, $urandom, av, ard, $urandom);
            check_model($sformatf("rnd%0d", c));
        end
        $display("random: 3000 cycles compared against queue model");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
